// File: rtl/gf11_reduce_seq_if.sv
// Handshake bundle for the GF(2^11) reducer: product in, reduced element out.
interface gf11_reduce_seq_if #(parameter int N = 11);
  logic              in_valid;
  logic              in_ready;
  logic [2*N-2:0]    p;
  logic              out_valid;
  logic              out_ready;
  logic [N-1:0]      c;
  logic              busy;

  modport master (output in_valid, p, out_ready, input in_ready, out_valid, c, busy);
  modport slave  (input in_valid, p, out_ready, output in_ready, out_valid, c, busy);
endinterface

// File: rtl/gf11_reduce_seq.sv
// Sequential reduction of a 21-bit GF(2) product modulo x^11 + x^2 + 1.
// One high coefficient is folded per cycle, from x^20 down to x^11, using
// x^k = x^(k-9) + x^(k-11). Fixed 10-step schedule, no data-dependent exit.
// Only N = 11 is meaningful; the fold taps are hard-wired to this polynomial.
module gf11_reduce_seq #(
  parameter int N = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  gf11_reduce_seq_if.slave   bus
);
  localparam int         PW     = 2*N-1;
  localparam logic [4:0] K_TOP  = 5'(PW-1);
  localparam logic [4:0] K_LAST = 5'(N);

  typedef enum logic [1:0] {IDLE, REDUCE, DONE} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] r, r_nxt, step_mask;
  logic [4:0]    k, k_nxt;

  // Fold pattern for the current position: clear x^k, toggle x^(k-9) and x^(k-11).
  always_comb begin
    step_mask = (PW'(1) << k) | (PW'(1) << (k - 5'd9)) | (PW'(1) << (k - 5'd11));
  end

  // Next-state and datapath update; the fold is applied only when r[k] is set.
  always_comb begin
    state_nxt = state;
    r_nxt     = r;
    k_nxt     = k;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          r_nxt     = bus.p;
          k_nxt     = K_TOP;
          state_nxt = REDUCE;
        end
      end
      REDUCE: begin
        if (r[k]) r_nxt = r ^ step_mask;
        k_nxt = k - 5'd1;
        if (k == K_LAST) state_nxt = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, remainder and step index registers; reset discards any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      r     <= '0;
      k     <= K_TOP;
    end else begin
      state <= state_nxt;
      r     <= r_nxt;
      k     <= k_nxt;
    end
  end

  // All outputs decode registered state only; nothing combinational from p/in_valid.
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.c         = r[N-1:0];

endmodule

// File: tb/tb_gf11_reduce_seq.sv
// Directed and randomized bench for gf11_reduce_seq.
module tb_gf11_reduce_seq;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   passed = 0;

  gf11_reduce_seq_if #(.N(11)) bus ();

  gf11_reduce_seq #(.N(11)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Carry-less 11x11 product (what the upstream multiplier delivers).
  function automatic logic [20:0] clmul(input logic [10:0] a, input logic [10:0] b);
    logic [20:0] acc;
    acc = '0;
    for (int i = 0; i < 11; i++) if (b[i]) acc ^= (21'(a) << i);
    return acc;
  endfunction

  // Multiply by x modulo x^11 + x^2 + 1.
  function automatic logic [10:0] xtime(input logic [10:0] v);
    logic [11:0] s;
    s = {v, 1'b0};
    if (s[11]) s ^= 12'h805;
    return s[10:0];
  endfunction

  // Reference field multiply, Horner style with reduction at every step.
  function automatic logic [10:0] gf_mul(input logic [10:0] a, input logic [10:0] b);
    logic [10:0] res;
    res = '0;
    for (int i = 10; i >= 0; i--) begin
      res = xtime(res);
      if (b[i]) res ^= a;
    end
    return res;
  endfunction

  // Present pv, wait for acceptance, then count edges until out_valid (bounded).
  task automatic send(input logic [20:0] pv, output logic [10:0] cg, output int lat);
    int n;
    bus.p = pv;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    cg = bus.c;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.p = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); else passed++;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", bus.busy); else passed++;
    checks++; if (bus.c !== 11'h000) $display("FAIL rst_c got=%h exp=000", bus.c); else passed++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) $display("FAIL post_rst_idle in_ready=%b busy=%b exp 1/0", bus.in_ready, bus.busy); else passed++;
  endtask

  task automatic test_vectors();
    logic [20:0] pv [7];
    logic [10:0] ev [7];
    logic [10:0] cg;
    int lat;
    pv = '{21'h000800, 21'h100000, 21'h001000, 21'h0007FF, 21'h000000, 21'h080000, 21'h002000};
    ev = '{11'h005,    11'h205,    11'h00A,    11'h7FF,    11'h000,    11'h500,    11'h014};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send(pv[i], cg, lat);
      checks++; if (cg !== ev[i]) $display("FAIL vec%0d_c p=%h got=%h exp=%h", i, pv[i], cg, ev[i]); else passed++;
      checks++; if (lat !== 10) $display("FAIL vec%0d_latency got=%0d exp=10", i, lat); else passed++;
      checks++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) $display("FAIL vec%0d_done_flags in_ready=%b busy=%b exp 0/1", i, bus.in_ready, bus.busy); else passed++;
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) $display("FAIL vec%0d_one_pulse out_valid=%b in_ready=%b exp 0/1", i, bus.out_valid, bus.in_ready); else passed++;
    end
  endtask

  task automatic test_backpressure();
    logic [10:0] cg;
    int lat;
    bus.out_ready = 1'b0;
    send(21'h001000, cg, lat);
    checks++; if (cg !== 11'h00A) $display("FAIL bp_c got=%h exp=00A", cg); else passed++;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0];
      bus.p = 21'h100000;
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b1 || bus.c !== 11'h00A || bus.in_ready !== 1'b0)
        $display("FAIL bp_hold%0d out_valid=%b c=%h in_ready=%b exp 1/00A/0", i, bus.out_valid, bus.c, bus.in_ready); else passed++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL bp_release out_valid=%b in_ready=%b busy=%b exp 0/1/0", bus.out_valid, bus.in_ready, bus.busy); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [10:0] cg;
    int lat;
    int seen;
    bus.out_ready = 1'b1;
    bus.p = 21'h1FFFFF;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b1) $display("FAIL mid_busy_before got=%b exp=1", bus.busy); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.c !== 11'h000)
      $display("FAIL mid_rst_outputs in_ready=%b out_valid=%b busy=%b c=%h exp 1/0/0/000", bus.in_ready, bus.out_valid, bus.busy, bus.c); else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    checks++; if (seen !== 0) $display("FAIL mid_no_out_valid got=%0d pulses exp=0", seen); else passed++;
    send(21'h100000, cg, lat);
    checks++; if (cg !== 11'h205) $display("FAIL mid_after_c got=%h exp=205", cg); else passed++;
    checks++; if (lat !== 10) $display("FAIL mid_after_latency got=%0d exp=10", lat); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [10:0] a, b, cg, ev;
    int lat, gap, hold;
    for (int i = 0; i < 1000; i++) begin
      a = 11'($urandom_range(0, 2047));
      b = 11'($urandom_range(0, 2047));
      ev = gf_mul(a, b);
      gap = $urandom_range(0, 3);
      hold = $urandom_range(0, 3);
      bus.in_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      bus.out_ready = 1'b0;
      send(clmul(a, b), cg, lat);
      checks++; if (cg !== ev) $display("FAIL rnd%0d_c a=%h b=%h got=%h exp=%h", i, a, b, cg, ev); else passed++;
      checks++; if (lat !== 10) $display("FAIL rnd%0d_latency got=%0d exp=10", i, lat); else passed++;
      repeat (hold) begin @(posedge clk); #1; end
      checks++; if (bus.out_valid !== 1'b1 || bus.c !== ev) $display("FAIL rnd%0d_hold out_valid=%b c=%h exp 1/%h", i, bus.out_valid, bus.c, ev); else passed++;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [20:0] pv [5];
    logic [10:0] ev [5];
    int acc_n, out_n, last_acc, cyc;
    logic acc;
    pv = '{21'h000800, 21'h100000, 21'h001000, 21'h0007FF, 21'h080000};
    ev = '{11'h005,    11'h205,    11'h00A,    11'h7FF,    11'h500};
    acc_n = 0; out_n = 0; last_acc = 0; cyc = 0;
    bus.out_ready = 1'b1;
    bus.p = pv[0];
    bus.in_valid = 1'b1;
    while (out_n < 5 && cyc < 200) begin
      acc = bus.in_ready & bus.in_valid;
      if (bus.out_valid) begin
        checks++; if (bus.c !== ev[out_n]) $display("FAIL b2b_c%0d got=%h exp=%h", out_n, bus.c, ev[out_n]); else passed++;
        out_n++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        if (acc_n > 0) begin
          checks++; if (cyc - last_acc !== 12) $display("FAIL b2b_interval%0d got=%0d exp=12", acc_n, cyc - last_acc); else passed++;
        end
        last_acc = cyc;
        acc_n++;
        if (acc_n < 5) bus.p = pv[acc_n];
        else bus.in_valid = 1'b0;
      end
    end
    checks++; if (acc_n !== 5 || out_n !== 5) $display("FAIL b2b_counts accepts=%0d results=%0d exp 5/5", acc_n, out_n); else passed++;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
